// File: rtl/pmu_sample_sequencer_if.sv
// PMU sample sequencer bus bundle: bank read port, bank write port, sample stream.
// master = sequencer side (drives requests and samples); slave = bank/consumer side.
interface pmu_sample_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  rd_valid_i;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  wr_valid_i;
  logic                  smp_valid_o;
  logic                  smp_ready_i;
  logic [ADDR_WIDTH-1:0] smp_addr_o;
  logic [DATA_WIDTH-1:0] smp_data_o;
  logic                  smp_last_o;

  modport master (
    output rd_en_o, rd_addr_o,
    input  rd_valid_i, rd_data_i,
    output wr_en_o, wr_addr_o, wr_data_o,
    input  wr_valid_i,
    output smp_valid_o, smp_addr_o,
    output smp_data_o, smp_last_o,
    input  smp_ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o,
    output rd_valid_i, rd_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o,
    output wr_valid_i,
    input  smp_valid_o, smp_addr_o,
    input  smp_data_o, smp_last_o,
    output smp_ready_i
  );
endinterface

// File: rtl/pmu_sample_sequencer.sv
// PMU sample sequencer: timer/manual-triggered sweep of the counter bank into a sample stream.
// Ports: clk, rst (async, active-high); cfg_enable_i, cfg_interval_i, start_i,
// clr_status_i; bus (bank rd/wr four-phase ports + smp valid/ready stream);
// busy_o, sweep_cnt_o, overrun_o, err_o.
// Macro PMU_SAMPLE_CLEAR_EN: end each sweep with a 0x3 then 0x1 write to CFG_ADDR.
module pmu_sample_sequencer #(
  parameter int NUM_COUNTERS   = 23,
  parameter int CFG_ADDR       = 23,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable_i,
  input  logic [31:0] cfg_interval_i,
  input  logic        start_i,
  input  logic        clr_status_i,
  pmu_sample_sequencer_if.master bus,
  output logic        busy_o,
  output logic [15:0] sweep_cnt_o,
  output logic        overrun_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_REL,
    PUSH,
`ifdef PMU_SAMPLE_CLEAR_EN
    CLR_REQ,
    CLR_REL,
`endif
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [TW-1:0]         tmo;
  logic [31:0]           timer;
  logic                  tick;
  logic                  wait_to;
  logic                  is_last;

  assign tick = cfg_enable_i && (cfg_interval_i != 32'd0) &&
                (timer == cfg_interval_i - 32'd1);
  assign wait_to = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign is_last = (idx == ADDR_WIDTH'(NUM_COUNTERS - 1));
  assign busy_o  = (state != IDLE);

`ifdef PMU_SAMPLE_CLEAR_EN
  logic clr_ph;
  logic wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
`else
  logic unused_wr;
  assign unused_wr     = bus.wr_valid_i;
  assign bus.wr_en_o   = 1'b0;
  assign bus.wr_addr_o = '0;
  assign bus.wr_data_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      tmo             <= '0;
      timer           <= '0;
      sweep_cnt_o     <= '0;
      overrun_o       <= 1'b0;
      err_o           <= 1'b0;
      bus.rd_en_o     <= 1'b0;
      bus.rd_addr_o   <= '0;
      bus.smp_valid_o <= 1'b0;
      bus.smp_addr_o  <= '0;
      bus.smp_data_o  <= '0;
      bus.smp_last_o  <= 1'b0;
`ifdef PMU_SAMPLE_CLEAR_EN
      clr_ph          <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
`endif
    end else begin
      if (!cfg_enable_i || cfg_interval_i == 32'd0 || tick)
        timer <= '0;
      else
        timer <= timer + 32'd1;

      // clear first so a same-cycle set below takes priority
      if (clr_status_i) begin
        overrun_o <= 1'b0;
        err_o     <= 1'b0;
      end
      if (tick && state != IDLE)
        overrun_o <= 1'b1;

      unique case (state)
        IDLE: begin
          if (tick || start_i) begin
            state         <= RD_REQ;
            bus.rd_en_o   <= 1'b1;
            bus.rd_addr_o <= idx;
            tmo           <= '0;
          end
        end
        RD_REQ: begin
          if (bus.rd_valid_i) begin
            bus.rd_en_o    <= 1'b0;
            bus.smp_data_o <= bus.rd_data_i;
            state          <= RD_REL;
            tmo            <= '0;
          end else if (wait_to) begin
            bus.rd_en_o    <= 1'b0;
            bus.smp_data_o <= '0;
            err_o          <= 1'b1;
            state          <= RD_REL;
            tmo            <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RD_REL: begin
          if (!bus.rd_valid_i || wait_to) begin
            if (bus.rd_valid_i) begin
              err_o          <= 1'b1;
              bus.smp_data_o <= '0;
            end
            bus.smp_valid_o <= 1'b1;
            bus.smp_addr_o  <= idx;
            bus.smp_last_o  <= is_last;
            state           <= PUSH;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        PUSH: begin
          if (bus.smp_ready_i) begin
            bus.smp_valid_o <= 1'b0;
            bus.smp_last_o  <= 1'b0;
            tmo             <= '0;
            if (!is_last) begin
              idx           <= idx + 1'b1;
              bus.rd_addr_o <= idx + 1'b1;
              bus.rd_en_o   <= 1'b1;
              state         <= RD_REQ;
            end else begin
`ifdef PMU_SAMPLE_CLEAR_EN
              wr_en_q   <= 1'b1;
              wr_addr_q <= ADDR_WIDTH'(CFG_ADDR);
              wr_data_q <= DATA_WIDTH'(3);
              clr_ph    <= 1'b0;
              state     <= CLR_REQ;
`else
              state     <= DONE;
`endif
            end
          end
        end
`ifdef PMU_SAMPLE_CLEAR_EN
        CLR_REQ: begin
          if (bus.wr_valid_i) begin
            wr_en_q <= 1'b0;
            state   <= CLR_REL;
            tmo     <= '0;
          end else if (wait_to) begin
            wr_en_q <= 1'b0;
            err_o   <= 1'b1;
            state   <= DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CLR_REL: begin
          if (!bus.wr_valid_i) begin
            // second pass drops the bank reset bit, keeps enable
            if (!clr_ph) begin
              clr_ph    <= 1'b1;
              wr_data_q <= DATA_WIDTH'(1);
              wr_en_q   <= 1'b1;
              tmo       <= '0;
              state     <= CLR_REQ;
            end else begin
              state <= DONE;
            end
          end else if (wait_to) begin
            err_o <= 1'b1;
            state <= DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
`endif
        DONE: begin
          sweep_cnt_o <= sweep_cnt_o + 16'd1;
          idx         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pmu_sample_sequencer.md
# pmu_sample_sequencer

Periodic sampling controller for the per-tile PMU counter bank. A programmable interval timer (or a manual start pulse) triggers a sweep that reads counters 0..NUM_COUNTERS-1 over the bank's level-handshake read port and streams each value out as a valid/ready sample. It optionally clears the bank through the write port once a sweep completes. It sits beside the NoC-facing counter access path and owns the bank's read/write ports while a sweep is active.

## Interface
- NUM_COUNTERS, 23, counters swept per sweep (addresses 0..NUM_COUNTERS-1)
- CFG_ADDR, 23, address of the bank config register
- ADDR_WIDTH, 8, counter address width
- DATA_WIDTH, 64, counter data width
- TIMEOUT_CYCLES, 255, maximum wait for a bank handshake edge
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- cfg_enable_i  in  1  enables the interval timer
- cfg_interval_i  in  32  sweep period in cycles; 0 disables the timer
- start_i  in  1  one-cycle manual sweep request
- clr_status_i  in  1  clears overrun_o and err_o
- rd_en_o  out  1  bank read request (level)
- rd_addr_o  out  ADDR_WIDTH  bank read address
- rd_valid_i  in  1  bank read acknowledge (level)
- rd_data_i  in  DATA_WIDTH  bank read data, valid while rd_valid_i is high
- wr_en_o  out  1  bank write request (level)
- wr_addr_o  out  ADDR_WIDTH  bank write address
- wr_data_o  out  DATA_WIDTH  bank write data
- wr_valid_i  in  1  bank write acknowledge (level)
- smp_valid_o  out  1  sample valid
- smp_ready_i  in  1  sample ready
- smp_addr_o  out  ADDR_WIDTH  counter index of the sample
- smp_data_o  out  DATA_WIDTH  counter value
- smp_last_o  out  1  marks the last sample of a sweep
- busy_o  out  1  high whenever the FSM is not in IDLE
- sweep_cnt_o  out  16  completed sweeps; wraps at 0xFFFF to 0
- overrun_o  out  1  sticky: a timer tick was dropped while busy
- err_o  out  1  sticky: a handshake timeout occurred

## Operation
- Reset values: all outputs 0. FSM in IDLE. Timer 0. Address index 0.
- Timer: counts while cfg_enable_i=1 and cfg_interval_i!=0. When the count equals cfg_interval_i-1 it emits a tick and returns to 0. Deasserting cfg_enable_i holds the timer at 0.
- Trigger = tick OR start_i.
  - In IDLE, a trigger starts a sweep.
  - A tick arriving while busy sets overrun_o and is dropped.
  - start_i arriving while busy is ignored silently.
- FSM states:
  - IDLE: waits for a trigger, then goes to RD_REQ.
  - RD_REQ: rd_en_o=1, rd_addr_o=index. On rd_valid_i=1, captures rd_data_i into the sample register and goes to RD_REL.
  - RD_REL: rd_en_o=0. Waits for rd_valid_i=0, then goes to PUSH.
  - PUSH: smp_valid_o=1. smp_last_o=1 when index==NUM_COUNTERS-1. On smp_ready_i:
    - not last: index++ and go to RD_REQ;
    - last: go to CLR_REQ if clearing is compiled in, else DONE.
  - CLR_REQ: wr_en_o=1, wr_addr_o=CFG_ADDR, wr_data_o=0x3 (enable + reset). Waits for wr_valid_i=1, then goes to CLR_REL.
  - CLR_REL: wr_en_o=0. Waits for wr_valid_i=0, then drives wr_data_o=0x1 and repeats the REQ/REL pair once to drop the reset bit, then goes to DONE.
  - DONE: sweep_cnt_o++, index=0, go to IDLE.
- Timeout: each REQ/REL wait counts cycles. If the count reaches TIMEOUT_CYCLES:
  - set err_o and release the request;
  - a read timeout pushes a sample with smp_data_o=0;
  - a write timeout proceeds to DONE.
- clr_status_i clears overrun_o and err_o the next cycle. If a set condition occurs in the same cycle, the set wins.
- smp_addr_o, smp_data_o and smp_last_o stay stable while smp_valid_o=1 and smp_ready_i=0.
- rst asserted mid-sweep aborts immediately: all request outputs go low and no partial sweep is counted.

## Timing
- Trigger at cycle T → rd_en_o=1 at T+1.
- rd_valid_i seen high at cycle R → rd_en_o=0 at R+1.
- rd_valid_i seen low at cycle L → smp_valid_o=1 at L+1.
- Handshake at cycle P → next rd_en_o=1 at P+1, or the DONE state at P+1.
- sweep_cnt_o updates on the cycle after DONE.
- busy_o is high from T+1 until the IDLE re-entry.
- Requests are level, four-phase. A new request is never raised while the bank acknowledge is still high.

## Configuration
- PMU_SAMPLE_CLEAR_EN defined: every sweep ends with the CLR_REQ/CLR_REL write sequence (0x3 then 0x1 to CFG_ADDR).
- Not defined: the CLR states are removed, PUSH of the last sample goes directly to DONE, and wr_en_o, wr_addr_o and wr_data_o are tied to 0.

## Test plan
- Manual sweep: start_i, bank acknowledges after 2 cycles, counter i holds 0x100+i → 23 samples, addresses 0..22, data 0x100..0x116, smp_last_o only on address 22, sweep_cnt_o=1.
- Backpressure: smp_ready_i low for 5 cycles on sample 4 → sample 4 held stable, no bank request during the stall.
- Timer/overrun: cfg_interval_i=10 with sweeps longer than 10 cycles → overrun_o=1 after the second tick. clr_status_i → overrun_o=0.
- Timeout: rd_valid_i stuck low on address 7 → after 255 cycles err_o=1, sample 7 carries data 0, sweep completes.
- Clear (PMU_SAMPLE_CLEAR_EN): writes 0x3 then 0x1 to address 23 after the last sample. Without the macro, wr_en_o is never asserted.
- Reset mid-sweep at address 10 → all outputs 0 the next cycle. A new start_i restarts at address 0 with sweep_cnt_o unchanged.
